// File: rtl/gp_timer_pkg.sv
// gp_timer_pkg: register map constants, CTRL bit positions and shared helpers
// for the multi-channel general-purpose timer.
// Build option: define GP_TIMER_CASCADE_EN to enable channel chaining (CTRL.chain).
package gp_timer_pkg;

  // Register index within a channel window (addr[1:0]).
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLR      = 3;
  localparam int CTRL_CHAIN    = 4;
  localparam int CTRL_P_LSB    = 16;

`ifdef GP_TIMER_CASCADE_EN
  localparam bit CASCADE_EN = 1'b1;
`else
  localparam bit CASCADE_EN = 1'b0;
`endif

  // Merge bus write data into a current register image, one byte lane per we bit.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{be[i]}};
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/gp_timer_channel.sv
// gp_timer_channel: one timer channel -- prescaler, counter, compare match,
// one-shot/periodic control and masked pending flag. Chaining to the previous
// channel's match is available only when CHAIN_OK is set by the top level.
module gp_timer_channel
  import gp_timer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16,
  parameter bit CHAIN_OK   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  reg_sel,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  input  logic        match_in,
  output logic [31:0] rd_val,
  output logic        match,
  output logic        irq
);

  logic                  en, periodic, irq_en, chain, pending;
  logic [PRESCALE_W-1:0] p, pcnt;
  logic [WIDTH-1:0]      compare, count;
  logic [31:0]           ctrl_val, merged;
  logic                  ctrl_wr, compare_wr, count_wr, status_wr;
  logic                  clr, en_on, en_off, tick_src, tick;

  // Assemble the CTRL read image; clr is a strobe and always reads 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ctrl_val                           = '0;
    ctrl_val[CTRL_EN]                  = en;
    ctrl_val[CTRL_PERIODIC]            = periodic;
    ctrl_val[CTRL_IRQ_EN]              = irq_en;
    ctrl_val[CTRL_CHAIN]               = chain;
    ctrl_val[CTRL_P_LSB +: PRESCALE_W] = p;
  end

  // Read value of the addressed register, zero-extended to 32 bits.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:    rd_val = ctrl_val;
      REG_COMPARE: rd_val = 32'(compare);
      REG_COUNT:   rd_val = 32'(count);
      default:     rd_val = 32'(pending);
    endcase
  end

  assign merged     = byte_merge(rd_val, wdata, we);
  assign ctrl_wr    = wr && (reg_sel == REG_CTRL);
  assign compare_wr = wr && (reg_sel == REG_COMPARE);
  assign count_wr   = wr && (reg_sel == REG_COUNT);
  assign status_wr  = wr && (reg_sel == REG_STATUS);

  assign clr    = ctrl_wr && merged[CTRL_CLR];
  assign en_on  = ctrl_wr && !en && merged[CTRL_EN];
  assign en_off = ctrl_wr && en && !merged[CTRL_EN];

  // A tick is dropped when the same edge disables the channel, clears it or loads COUNT.
  assign tick_src = chain ? match_in : (pcnt == p);
  assign tick     = en && tick_src && !en_off && !clr && !count_wr;
  assign match    = tick && (count == compare);
  assign irq      = pending && irq_en;

  // CTRL fields: bus writes, plus self-disable on a one-shot match.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      chain    <= 1'b0;
      p        <= '0;
    end else if (ctrl_wr) begin
      en       <= merged[CTRL_EN];
      periodic <= merged[CTRL_PERIODIC];
      irq_en   <= merged[CTRL_IRQ_EN];
      chain    <= CHAIN_OK && merged[CTRL_CHAIN];
      p        <= merged[CTRL_P_LSB +: PRESCALE_W];
    end else if (match && !periodic) begin
      en <= 1'b0;
    end
  end

  // Prescaler: counts 0..P, restarts on enable, clr or COUNT load; frozen while chained.
  always_ff @(posedge clk) begin
    if (reset)                          pcnt <= '0;
    else if (clr || count_wr || en_on)  pcnt <= '0;
    else if (en && !en_off && !chain)   pcnt <= (pcnt == p) ? '0 : pcnt + PRESCALE_W'(1);
  end

  // Counter: bus load wins, then clr, then tick (match returns it to 0).
  always_ff @(posedge clk) begin
    if (reset)         count <= '0;
    else if (count_wr) count <= merged[WIDTH-1:0];
    else if (clr)      count <= '0;
    else if (tick)     count <= match ? '0 : count + WIDTH'(1);
  end

  // Compare register, all ones out of reset.
  always_ff @(posedge clk) begin
    if (reset)           compare <= '1;
    else if (compare_wr) compare <= merged[WIDTH-1:0];
  end

  // Pending flag: a match sets it and beats a same-edge write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset)                              pending <= 1'b0;
    else if (match)                         pending <= 1'b1;
    else if (status_wr && we[0] && wdata[0]) pending <= 1'b0;
  end

endmodule

// File: rtl/gp_timer_multi.sv
// gp_timer_multi: NUM_CH-channel general-purpose timer on the FemtoRV32 bus.
// Holds the {channel, reg} address decode, the read mux and the interrupt OR.
// Build option: define GP_TIMER_CASCADE_EN so channel n>=1 can count channel n-1 matches.
module gp_timer_multi
  import gp_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       select,
  input  logic [3:0]                 we,
  input  logic [$clog2(NUM_CH)+1:0]  addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic                       interrupt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_idx;
  logic              bus_wr;
  logic [31:0]       ch_rd [NUM_CH];
  logic [NUM_CH-1:0] match, upstream;

  generate
    if (NUM_CH > 1) begin : g_idx
      assign ch_idx = addr[$clog2(NUM_CH)+1:2];
    end else begin : g_idx1
      assign ch_idx = '0;
    end
  endgenerate

  assign bus_wr   = select && (we != 4'b0000);
  // Channel n sees channel n-1's match; channel 0 has no upstream.
  assign upstream = match << 1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gp_timer_channel #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W),
      .CHAIN_OK   (CASCADE_EN && (i > 0))
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr       (bus_wr && (ch_idx == CH_W'(i))),
      .reg_sel  (addr[1:0]),
      .we       (we),
      .wdata    (wdata),
      .match_in (upstream[i]),
      .rd_val   (ch_rd[i]),
      .match    (match[i]),
      .irq      (irq_vec[i])
    );
  end

  // Read mux: unselected or out-of-range channel reads 0.
  always_comb begin
    rdata = '0;
    if (select && (int'(ch_idx) < NUM_CH)) rdata = ch_rd[ch_idx];
  end

  assign interrupt = |irq_vec;

endmodule

// File: tb/tb_gp_timer_multi.sv
// tb_gp_timer_multi: directed self-checking bench for gp_timer_multi
// (NUM_CH=4, WIDTH=32, PRESCALE_W=16). Cascade checks run when GP_TIMER_CASCADE_EN is defined.
module tb_gp_timer_multi;

  logic        clk = 1'b0;
  logic        reset, select;
  logic [3:0]  we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  irq_vec;
  logic        interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  gp_timer_multi #(.NUM_CH(4), .WIDTH(32), .PRESCALE_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .select    (select),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_vec   (irq_vec),
    .interrupt (interrupt)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance n clock edges; return 1 ns after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus write, taking effect at the next edge.
  task automatic bus_write(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
    addr   = 4'(ch * 4 + r);
    wdata  = d;
    we     = be;
    select = 1'b1;
    @(posedge clk);
    #1;
    select = 1'b0;
    we     = 4'b0000;
  endtask

  task automatic chk_reg(input string tag, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] v;
    addr   = 4'(ch * 4 + r);
    select = 1'b1;
    #1;
    v      = rdata;
    select = 1'b0;
    check(tag, v, exp);
  endtask

  initial begin
    reset = 1'b1; select = 1'b0; we = '0; addr = '0; wdata = '0;
    step(3);
    reset = 1'b0;
    step(1);

    // Reset state of every register.
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        chk_reg($sformatf("rst_ch%0d_r%0d", c, r), c, r, (r == 1) ? 32'hFFFF_FFFF : 32'd0);

    // Unselected reads return 0.
    addr = 4'(1); select = 1'b0; #1;
    check("rdata_unselected", rdata, 32'd0);

    // ch0 periodic, COMPARE=3, P=0, irq enabled.
    bus_write(0, 1, 32'd3, 4'hF);
    bus_write(0, 0, 32'h7, 4'hF);               // E0
    chk_reg("ch0_count_e0", 0, 2, 32'd0);
    step(3);                                     // E3
    chk_reg("ch0_count_e3", 0, 2, 32'd3);
    check("ch0_int_e3", 32'(interrupt), 32'd0);
    step(1);                                     // E4: match
    chk_reg("ch0_pend_e4", 0, 3, 32'd1);
    chk_reg("ch0_count_e4", 0, 2, 32'd0);
    check("ch0_int_e4", 32'(interrupt), 32'd1);
    check("ch0_vec_e4", 32'(irq_vec), 32'h1);
    bus_write(0, 3, 32'd1, 4'hF);               // E5: W1C
    check("ch0_int_cleared", 32'(interrupt), 32'd0);
    chk_reg("ch0_count_e5", 0, 2, 32'd1);
    step(2);                                     // E7
    check("ch0_int_e7", 32'(interrupt), 32'd0);
    step(1);                                     // E8: next match
    check("ch0_int_e8", 32'(interrupt), 32'd1);
    bus_write(0, 0, 32'h0, 4'hF);               // E9: disabling drops the tick
    chk_reg("ch0_count_disable", 0, 2, 32'd0);
    step(3);
    chk_reg("ch0_count_hold", 0, 2, 32'd0);
    bus_write(0, 3, 32'd1, 4'hF);
    chk_reg("ch0_pend_clear", 0, 3, 32'd0);
    check("ch0_int_off", 32'(interrupt), 32'd0);

    // ch3 simultaneous events, COMPARE=2, P=0, irq masked.
    bus_write(3, 1, 32'd2, 4'hF);
    bus_write(3, 0, 32'h3, 4'hF);               // E0
    step(2);                                     // E2: count=2
    bus_write(3, 3, 32'd1, 4'hF);               // E3: match and W1C together
    chk_reg("ch3_set_wins", 3, 3, 32'd1);
    chk_reg("ch3_count_match", 3, 2, 32'd0);
    check("ch3_masked_vec", 32'(irq_vec), 32'd0);
    bus_write(3, 2, 32'h10, 4'hF);              // COUNT load on a tick edge
    chk_reg("ch3_count_load", 3, 2, 32'h10);
    step(1);
    chk_reg("ch3_count_after_load", 3, 2, 32'h11);
    bus_write(3, 0, 32'hB, 4'hF);               // clr on a tick edge
    chk_reg("ch3_count_clr", 3, 2, 32'd0);
    chk_reg("ch3_ctrl_clr_reads0", 3, 0, 32'h3);
    step(1);
    chk_reg("ch3_count_after_clr", 3, 2, 32'd1);
    bus_write(3, 0, 32'h0, 4'hF);
    bus_write(3, 3, 32'd1, 4'hF);

    // ch1 one-shot, COMPARE=9, P=4, irq enabled: match 50 cycles after enable.
    bus_write(1, 1, 32'd9, 4'hF);
    bus_write(1, 0, 32'h0004_0005, 4'hF);       // E0
    step(4);                                     // E4
    chk_reg("ch1_count_e4", 1, 2, 32'd0);
    step(1);                                     // E5: first tick
    chk_reg("ch1_count_e5", 1, 2, 32'd1);
    step(44);                                    // E49
    chk_reg("ch1_count_e49", 1, 2, 32'd9);
    chk_reg("ch1_pend_e49", 1, 3, 32'd0);
    step(1);                                     // E50
    chk_reg("ch1_pend_e50", 1, 3, 32'd1);
    chk_reg("ch1_ctrl_oneshot", 1, 0, 32'h0004_0004);
    check("ch1_int_e50", 32'(interrupt), 32'd1);
    step(20);
    chk_reg("ch1_count_stays0", 1, 2, 32'd0);
    bus_write(1, 3, 32'd1, 4'hF);
    check("ch1_int_cleared", 32'(interrupt), 32'd0);

    // ch2 wrap-around: COUNT above COMPARE runs to all ones then wraps.
    bus_write(2, 1, 32'd5, 4'hF);
    bus_write(2, 2, 32'd7, 4'hF);
    bus_write(2, 0, 32'h3, 4'hF);               // E0
    chk_reg("ch2_count_e0", 2, 2, 32'd7);
    step(1);
    chk_reg("ch2_count_above", 2, 2, 32'd8);
    bus_write(2, 2, 32'hFFFF_FFFE, 4'hF);
    chk_reg("ch2_count_fffe", 2, 2, 32'hFFFF_FFFE);
    step(1);
    chk_reg("ch2_count_ffff", 2, 2, 32'hFFFF_FFFF);
    step(1);
    chk_reg("ch2_count_wrap", 2, 2, 32'd0);
    chk_reg("ch2_pend_wrap", 2, 3, 32'd0);
    step(5);
    chk_reg("ch2_count_5", 2, 2, 32'd5);
    step(1);
    chk_reg("ch2_pend_match", 2, 3, 32'd1);
    chk_reg("ch2_count_match", 2, 2, 32'd0);
    bus_write(2, 0, 32'h0, 4'hF);
    bus_write(2, 3, 32'd1, 4'hF);
    bus_write(2, 1, 32'h1122_3344, 4'hF);
    bus_write(2, 1, 32'h5566_77AB, 4'b0001);
    chk_reg("ch2_byte_lane", 2, 1, 32'h1122_33AB);
    bus_write(2, 0, 32'hFFFF_FFF6, 4'hF);
`ifdef GP_TIMER_CASCADE_EN
    chk_reg("ch2_ctrl_fields", 2, 0, 32'hFFFF_0016);
`else
    chk_reg("ch2_ctrl_fields", 2, 0, 32'hFFFF_0006);
`endif
    bus_write(2, 0, 32'h0, 4'hF);

    // Reset mid-operation overrides a same-cycle write.
    bus_write(0, 1, 32'd0, 4'hF);
    bus_write(0, 0, 32'h7, 4'hF);
    step(1);
    check("pre_reset_int", 32'(interrupt), 32'd1);
    reset = 1'b1;
    bus_write(0, 1, 32'd5, 4'hF);
    reset = 1'b0;
    chk_reg("reset_compare", 0, 1, 32'hFFFF_FFFF);
    chk_reg("reset_ctrl", 0, 0, 32'd0);
    check("reset_int", 32'(interrupt), 32'd0);
    check("reset_vec", 32'(irq_vec), 32'd0);

`ifdef GP_TIMER_CASCADE_EN
    // ch1 chained to ch0 (COMPARE=1): ch1 with COMPARE=2 matches 6 cycles after ch0 starts.
    bus_write(1, 1, 32'd2, 4'hF);
    bus_write(1, 0, 32'h13, 4'hF);
    bus_write(0, 1, 32'd1, 4'hF);
    bus_write(0, 0, 32'h3, 4'hF);               // E0
    step(5);
    chk_reg("casc_ch1_count_e5", 1, 2, 32'd2);
    chk_reg("casc_ch1_pend_e5", 1, 3, 32'd0);
    step(1);
    chk_reg("casc_ch1_pend_e6", 1, 3, 32'd1);
    chk_reg("casc_ch0_ctrl", 0, 0, 32'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
